// File: rtl/frame_fifo_feeder_if.sv
// Memory read-burst port and line-FIFO write port of the frame fill stage.
// The master modport is the feeder side; the slave modport is the memory/FIFO side.
interface frame_fifo_feeder_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 10
);
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic [7:0]        mem_len;
    logic              mem_ack;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic [AW-1:0]     fifo_usedw;
    logic              fifo_full;
    logic              fifo_wrreq;
    logic [DATA_W-1:0] fifo_wdata;

    modport master (
        output mem_req, mem_addr, mem_len,
        input  mem_ack, mem_valid, mem_data,
        input  fifo_usedw, fifo_full,
        output fifo_wrreq, fifo_wdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_len,
        output mem_ack, mem_valid, mem_data,
        output fifo_usedw, fifo_full,
        input  fifo_wrreq, fifo_wdata
    );
endinterface

// File: rtl/frame_fifo_feeder.sv
// Frame FIFO feeder: fetches display lines from frame memory in bursts,
// writes them into the line FIFO and flags when a full line is buffered.
// Parameters are captured into a shadow set and only become active at a
// start from IDLE or at a frame wrap.
module frame_fifo_feeder #(
    parameter int DATA_W    = 16,
    parameter int AW        = 10,
    parameter int BURST_MAX = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                update_flag,
    input  logic [15:0]         trace_length,
    input  logic [15:0]         frame_lines,
    input  logic [31:0]         base_addr,
    input  logic                enable,
    frame_fifo_feeder_if.master bus,
    output logic                fifo_ready,
    output logic                frame_done,
    output logic                ovf_err
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_REQ   = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    localparam logic [15:0] BURST16  = 16'(BURST_MAX);
    localparam logic [AW:0] FREE_MAX = (AW+1)'((1 << AW) - 1);

    state_t      r_state;
    logic        r_upd_s1;
    logic        r_upd_s2;
    logic [15:0] r_sh_lw;
    logic [15:0] r_sh_fl;
    logic [31:0] r_sh_base;
    logic [15:0] r_act_lw;
    logic [15:0] r_act_fl;
    logic [15:0] r_word_left;
    logic [15:0] r_line_cnt;
    logic [15:0] r_burst_left;
    logic [15:0] r_len;
    logic [31:0] r_addr;
    logic        r_fd_pend;

    logic        w_upd_fall;
    logic [15:0] w_len;
    logic [AW:0] w_free;
    logic        w_space_ok;
    logic        w_line_end;
    logic        w_burst_end;
    logic [15:0] w_line_next;
    logic        w_frame_end;
    logic        w_unused_trace_lsb;

    // Odd pixel clock of a trace line carries no word of its own.
    assign w_unused_trace_lsb = trace_length[0];

    assign w_upd_fall  = r_upd_s2 & ~r_upd_s1;
    assign w_len       = (r_word_left > BURST16) ? BURST16 : r_word_left;
    assign w_free      = FREE_MAX - {1'b0, bus.fifo_usedw};
    assign w_space_ok  = (32'(w_free) >= 32'(w_len));
    assign w_line_end  = (r_word_left == 16'd1);
    assign w_burst_end = (r_burst_left == 16'd1);
    assign w_line_next = r_line_cnt + 16'd1;
    // Bursts never straddle a line, so a line end is always also a burst end.
    assign w_frame_end = w_line_end && (w_line_next == r_act_fl);

    // Synchronise update_flag and load the shadow set on its falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_upd_s1  <= 1'b0;
            r_upd_s2  <= 1'b0;
            r_sh_lw   <= 16'd0;
            r_sh_fl   <= 16'd0;
            r_sh_base <= 32'd0;
        end else begin
            r_upd_s1 <= update_flag;
            r_upd_s2 <= r_upd_s1;
            if (w_upd_fall) begin
                r_sh_lw   <= {1'b0, trace_length[15:1]};
                r_sh_fl   <= frame_lines;
                r_sh_base <= base_addr;
            end
        end
    end

    // Full-line-buffered flag, re-evaluated every cycle regardless of state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_ready <= 1'b0;
        end else begin
            fifo_ready <= (r_act_lw != 16'd0) && (32'(bus.fifo_usedw) >= 32'(r_act_lw));
        end
    end

    // Main fill FSM: space check, burst request, data transfer, line/frame accounting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_act_lw       <= 16'd0;
            r_act_fl       <= 16'd0;
            r_word_left    <= 16'd0;
            r_line_cnt     <= 16'd0;
            r_burst_left   <= 16'd0;
            r_len          <= 16'd0;
            r_addr         <= 32'd0;
            r_fd_pend      <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= 32'd0;
            bus.mem_len    <= 8'd0;
            bus.fifo_wrreq <= 1'b0;
            bus.fifo_wdata <= '0;
            frame_done     <= 1'b0;
            ovf_err        <= 1'b0;
        end else begin
            bus.fifo_wrreq <= 1'b0;
            frame_done     <= r_fd_pend;
            r_fd_pend      <= 1'b0;
            if (!enable) begin
                // Abandon everything in flight; ovf_err stays sticky.
                r_state      <= S_IDLE;
                r_word_left  <= 16'd0;
                r_line_cnt   <= 16'd0;
                r_burst_left <= 16'd0;
                r_len        <= 16'd0;
                r_addr       <= 32'd0;
                bus.mem_req  <= 1'b0;
                bus.mem_addr <= 32'd0;
                bus.mem_len  <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        bus.mem_req <= 1'b0;
                        if ((r_sh_lw != 16'd0) && (r_sh_fl != 16'd0)) begin
                            r_act_lw    <= r_sh_lw;
                            r_act_fl    <= r_sh_fl;
                            r_addr      <= r_sh_base;
                            r_line_cnt  <= 16'd0;
                            r_word_left <= r_sh_lw;
                            r_state     <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (w_space_ok) begin
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= r_addr;
                            bus.mem_len  <= w_len[7:0];
                            r_len        <= w_len;
                            r_state      <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (bus.mem_ack) begin
                            bus.mem_req  <= 1'b0;
                            r_burst_left <= r_len;
                            r_state      <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (bus.mem_valid) begin
                            // A word arriving on a full FIFO is lost but still counted.
                            bus.fifo_wrreq <= ~bus.fifo_full;
                            bus.fifo_wdata <= bus.mem_data;
                            if (bus.fifo_full) begin
                                ovf_err <= 1'b1;
                            end
                            r_burst_left <= r_burst_left - 16'd1;
                            r_word_left  <= r_word_left - 16'd1;
                            if (w_line_end) begin
                                r_line_cnt  <= w_line_next;
                                r_word_left <= r_act_lw;
                            end
                            if (w_burst_end) begin
                                r_addr  <= r_addr + 32'(r_len);
                                r_state <= S_CHECK;
                            end
                            if (w_frame_end) begin
                                // Frame wrap: the shadow set becomes active here.
                                r_line_cnt  <= 16'd0;
                                r_addr      <= r_sh_base;
                                r_act_lw    <= r_sh_lw;
                                r_act_fl    <= r_sh_fl;
                                r_word_left <= r_sh_lw;
                                r_fd_pend   <= 1'b1;
                                if ((r_sh_lw == 16'd0) || (r_sh_fl == 16'd0)) begin
                                    r_state <= S_IDLE;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
